chunked_adder: RTL and testbench



---
 rtl/chunked_adder_if.sv | 25 ++
 rtl/chunked_adder.sv | 86 ++++++++
 tb/tb_chunked_adder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_adder_if.sv
// Operand/result bundle for chunked_adder; the master side issues requests,
// the slave side (the adder) returns results and status.
interface chunked_adder_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Sub, A, B,
    input  Sum, Carry, Overflow, Busy, Done
  );

  modport slave (
    input  Start, Sub, A, B,
    output Sum, Carry, Overflow, Busy, Done
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and publishes Sum/Carry/Overflow with a one-cycle Done pulse.
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic            clk,
  input  logic            rst,
  chunked_adder_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, partial_reg, sum_reg;
  logic             carry_reg, carry_out_reg, overflow_reg;
  logic [CW-1:0]    count_reg;

  logic [CHUNK-1:0] a_chunk, b_chunk, chunk_sum;
  logic [WIDTH-1:0] result;
  logic             chunk_carry, msb_carry_in, last, accept;

  // Subtraction is A + ~B + 1, so B is inverted at capture and Sub seeds the carry.
  always_comb begin
    a_chunk = a_reg[count_reg*CHUNK +: CHUNK];
    b_chunk = b_reg[count_reg*CHUNK +: CHUNK];
    {chunk_carry, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
    msb_carry_in = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    last = (count_reg == CW'(N - 1));
    result = partial_reg;
    result[count_reg*CHUNK +: CHUNK] = chunk_sum;
    accept = bus.Start && (state_reg != RUN);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.Start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = bus.Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      partial_reg   <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      count_reg     <= '0;
    end else if (accept) begin
      a_reg       <= bus.A;
      b_reg       <= bus.B ^ {WIDTH{bus.Sub}};
      carry_reg   <= bus.Sub;
      partial_reg <= '0;
      count_reg   <= '0;
    end else if (state_reg == RUN) begin
      partial_reg <= result;
      carry_reg   <= chunk_carry;
      if (last) begin
        sum_reg       <= result;
        carry_out_reg <= chunk_carry;
        overflow_reg  <= chunk_carry ^ msb_carry_in;
      end else begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign bus.Sum      = sum_reg;
  assign bus.Carry    = carry_out_reg;
  assign bus.Overflow = overflow_reg;
  assign bus.Busy     = (state_reg == RUN);
  assign bus.Done     = (state_reg == DONE);
endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: vector table, handshake/reset
// sequences, and randomized operations against an arithmetic reference.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          sel;
  logic        start_drv, sub_drv;
  logic [15:0] a_drv, b_drv;

  chunked_adder_if #(.WIDTH(8))  bus8  ();
  chunked_adder_if #(.WIDTH(8))  bus8c ();
  chunked_adder_if #(.WIDTH(16)) bus16 ();

  chunked_adder #(.WIDTH(8),  .CHUNK(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  chunked_adder #(.WIDTH(8),  .CHUNK(8)) dut8c (.clk(clk), .rst(rst), .bus(bus8c));
  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  assign bus8.Start  = (sel == 0) ? start_drv : 1'b0;
  assign bus8.Sub    = sub_drv;
  assign bus8.A      = a_drv[7:0];
  assign bus8.B      = b_drv[7:0];
  assign bus8c.Start = (sel == 1) ? start_drv : 1'b0;
  assign bus8c.Sub   = sub_drv;
  assign bus8c.A     = a_drv[7:0];
  assign bus8c.B     = b_drv[7:0];
  assign bus16.Start = (sel == 2) ? start_drv : 1'b0;
  assign bus16.Sub   = sub_drv;
  assign bus16.A     = a_drv;
  assign bus16.B     = b_drv;

  logic [15:0] cur_sum;
  logic        cur_carry, cur_ovf, cur_busy, cur_done;
  always_comb begin
    cur_sum = {8'h00, bus8.Sum};
    cur_carry = bus8.Carry;
    cur_ovf = bus8.Overflow;
    cur_busy = bus8.Busy;
    cur_done = bus8.Done;
    if (sel == 1) begin
      cur_sum = {8'h00, bus8c.Sum};
      cur_carry = bus8c.Carry;
      cur_ovf = bus8c.Overflow;
      cur_busy = bus8c.Busy;
      cur_done = bus8c.Done;
    end else if (sel == 2) begin
      cur_sum = bus16.Sum;
      cur_carry = bus16.Carry;
      cur_ovf = bus16.Overflow;
      cur_busy = bus16.Busy;
      cur_done = bus16.Done;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {overflow, carry, sum[15:0]}.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic sub);
    longint m = longint'(1) << w;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint full, sa, sb, res;
    logic c, o;
    if (sub) begin
      full = ua - ub;
      c = (ua >= ub);
    end else begin
      full = ua + ub;
      c = (full >= m);
    end
    full = ((full % m) + m) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    res = sub ? sa - sb : sa + sb;
    o = (res >= m / 2) || (res < -(m / 2));
    return {o, c, 16'(full)};
  endfunction

  // Issues one request, optionally toggling inputs while busy, and returns at the Done cycle.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input bit noise, output logic [15:0] sum, output logic carry,
                        output logic ovf, output int busy_cnt, output bit done_seen);
    logic [15:0] held;
    bit held_ok;
    @(negedge clk);
    sel = s;
    start_drv = 1'b1;
    a_drv = a;
    b_drv = b;
    sub_drv = sub;
    @(negedge clk);
    start_drv = 1'b0;
    held = cur_sum;
    held_ok = 1'b1;
    busy_cnt = 0;
    while (cur_busy && busy_cnt < 40) begin
      busy_cnt++;
      if (cur_sum !== held) held_ok = 1'b0;
      if (noise) begin
        start_drv = 1'($urandom_range(0, 1));
        a_drv = 16'($urandom);
        b_drv = 16'($urandom);
        sub_drv = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start_drv = 1'b0;
    done_seen = cur_done;
    sum = cur_sum;
    carry = cur_carry;
    ovf = cur_ovf;
    check("sum_held_while_busy", 32'(held_ok), 32'd1);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] sum;
    logic       carry, ovf;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sum, a, b, mask;
    logic        carry, ovf, sub;
    logic [17:0] exp;
    int          busy, pulses;
    bit          done;

    vecs[0] = '{8'h3C, 8'h4F, 1'b0, 8'h8B, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0};

    rst = 1'b1;
    sel = 0;
    start_drv = 1'b0;
    sub_drv = 1'b0;
    a_drv = '0;
    b_drv = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(cur_busy), 32'd0);
    check("reset_done", 32'(cur_done), 32'd0);
    check("reset_sum", 32'(cur_sum), 32'd0);
    check("reset_carry", 32'(cur_carry), 32'd0);
    check("reset_ovf", 32'(cur_ovf), 32'd0);

    foreach (vecs[i]) begin
      run_op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].sub, 1'b0, sum, carry, ovf, busy, done);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy), 32'd4);
      check($sformatf("vec%0d_done", i), 32'(done), 32'd1);
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].carry));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      @(negedge clk);
      check($sformatf("vec%0d_done_fall", i), 32'(cur_done), 32'd0);
      check($sformatf("vec%0d_sum_hold", i), 32'(cur_sum), 32'(vecs[i].sum));
    end

    // Asynchronous reset while Done is showing a nonzero result.
    run_op(0, 16'h0080, 16'h0081, 1'b0, 1'b0, sum, carry, ovf, busy, done);
    check("pre_reset_sum", 32'(sum), 32'h01);
    #2 rst = 1'b1;
    #1;
    check("async_rst_done", 32'(cur_done), 32'd0);
    check("async_rst_sum", 32'(cur_sum), 32'd0);
    check("async_rst_carry", 32'(cur_carry), 32'd0);
    check("async_rst_ovf", 32'(cur_ovf), 32'd0);
    check("async_rst_busy", 32'(cur_busy), 32'd0);
    start_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("start_in_rst_busy%0d", i), 32'(cur_busy), 32'd0);
    end
    start_drv = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_busy", 32'(cur_busy), 32'd0);

    // Start during RUN is ignored.
    @(negedge clk);
    start_drv = 1'b1; a_drv = 16'h01; b_drv = 16'h02; sub_drv = 1'b0;
    @(negedge clk);
    start_drv = 1'b0;
    @(negedge clk);
    start_drv = 1'b1; a_drv = 16'h10; b_drv = 16'h20;
    @(negedge clk);
    start_drv = 1'b0;
    pulses = 0;
    sum = '0;
    for (int i = 0; i < 10; i++) begin
      if (cur_done) begin
        pulses++;
        sum = cur_sum;
      end
      @(negedge clk);
    end
    check("ignore_start_pulses", 32'(pulses), 32'd1);
    check("ignore_start_sum", 32'(sum), 32'h03);

    // Back-to-back: Start accepted in the Done cycle.
    run_op(0, 16'h11, 16'h22, 1'b0, 1'b0, sum, carry, ovf, busy, done);
    check("b2b_first_sum", 32'(sum), 32'h33);
    check("b2b_first_done", 32'(done), 32'd1);
    start_drv = 1'b1; a_drv = 16'h40; b_drv = 16'h05; sub_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    check("b2b_busy_next", 32'(cur_busy), 32'd1);
    check("b2b_done_fell", 32'(cur_done), 32'd0);
    busy = 0;
    while (cur_busy && busy < 40) begin
      busy++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", 32'(busy), 32'd4);
    check("b2b_second_done", 32'(cur_done), 32'd1);
    check("b2b_second_sum", 32'(cur_sum), 32'h3B);
    check("b2b_second_carry", 32'(cur_carry), 32'd1);

    // Abort mid-operation.
    @(negedge clk);
    start_drv = 1'b1; a_drv = 16'h3C; b_drv = 16'h4F; sub_drv = 1'b0;
    @(negedge clk);
    start_drv = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(cur_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy_now", 32'(cur_busy), 32'd0);
    check("abort_sum_now", 32'(cur_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cur_done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_sum_zero", 32'(cur_sum), 32'd0);

    // Randomized 8-bit operations with input noise during RUN.
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      sub = 1'($urandom_range(0, 1));
      exp = ref_op(8, a, b, sub);
      run_op(0, a, b, sub, 1'($urandom_range(0, 1)), sum, carry, ovf, busy, done);
      check($sformatf("rnd8_%0d_busy a=%0h b=%0h sub=%0d", i, a, b, sub), 32'(busy), 32'd4);
      check($sformatf("rnd8_%0d_res a=%0h b=%0h sub=%0d", i, a, b, sub),
            {14'd0, done, ovf, carry, sum}, {14'd0, 1'b1, exp});
    end

    // Single-chunk configuration.
    run_op(1, 16'h7F, 16'h01, 1'b0, 1'b0, sum, carry, ovf, busy, done);
    check("c8_busy_cycles", 32'(busy), 32'd1);
    check("c8_done", 32'(done), 32'd1);
    check("c8_sum", 32'(sum), 32'h80);
    check("c8_ovf", 32'(ovf), 32'd1);
    check("c8_carry", 32'(carry), 32'd0);

    // 16-bit, 4-bit chunks.
    run_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, sum, carry, ovf, busy, done);
    check("w16_busy_cycles", 32'(busy), 32'd4);
    check("w16_done", 32'(done), 32'd1);
    check("w16_sum", 32'(sum), 32'h0000);
    check("w16_carry", 32'(carry), 32'd1);
    mask = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom) & mask;
      b = 16'($urandom) & mask;
      sub = 1'($urandom_range(0, 1));
      exp = ref_op(16, a, b, sub);
      run_op(2, a, b, sub, 1'b1, sum, carry, ovf, busy, done);
      check($sformatf("rnd16_%0d_res a=%0h b=%0h sub=%0d", i, a, b, sub),
            {13'd0, 32'(busy) == 32'd4, done, ovf, carry, sum}, {13'd0, 1'b1, 1'b1, exp});
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
